// File: rtl/vga_scan_generator.sv
// Raster timing source: pixel/line counters, visible-area blank, active-low syncs,
// frame/line start strobes and a completed-frame counter, one pixel per enabled clock.
module vga_scan_generator #(
    parameter int H_ACTIVE = 640,
    parameter int H_FP     = 16,
    parameter int H_SYNC   = 96,
    parameter int H_BP     = 48,
    parameter int V_ACTIVE = 480,
    parameter int V_FP     = 10,
    parameter int V_SYNC   = 2,
    parameter int V_BP     = 33
) (
    input  logic        vga_clk,
    input  logic        reset,
    input  logic        pix_ce,
    output logic [9:0]  DrawX,
    output logic [9:0]  DrawY,
    output logic        blank,
    output logic        hs,
    output logic        vs,
    output logic        frame_start,
    output logic        line_start,
    output logic [15:0] frame_count
);

    localparam int H_TOTAL = H_ACTIVE + H_FP + H_SYNC + H_BP;
    localparam int V_TOTAL = V_ACTIVE + V_FP + V_SYNC + V_BP;

    localparam logic [9:0] H_ACT_END  = 10'(H_ACTIVE - 1);
    localparam logic [9:0] H_FP_END   = 10'(H_ACTIVE + H_FP - 1);
    localparam logic [9:0] H_SYNC_END = 10'(H_ACTIVE + H_FP + H_SYNC - 1);
    localparam logic [9:0] H_LAST     = 10'(H_TOTAL - 1);

    localparam logic [9:0] V_ACT_END  = 10'(V_ACTIVE - 1);
    localparam logic [9:0] V_FP_END   = 10'(V_ACTIVE + V_FP - 1);
    localparam logic [9:0] V_SYNC_END = 10'(V_ACTIVE + V_FP + V_SYNC - 1);
    localparam logic [9:0] V_LAST     = 10'(V_TOTAL - 1);

    typedef enum logic [1:0] {
        PH_ACTIVE,
        PH_FRONT,
        PH_SYNC,
        PH_BACK
    } phase_t;

    logic [9:0]  hCount_q, hCount_d;
    logic [9:0]  vCount_q, vCount_d;
    phase_t      hPhase_q, hPhase_d;
    phase_t      vPhase_q, vPhase_d;
    logic        lineWrap;

    logic        blank_q, blank_d;
    logic        hs_q, hs_d;
    logic        vs_q, vs_d;
    logic        frameStart_q, frameStart_d;
    logic        lineStart_q, lineStart_d;
    logic [15:0] frameCount_q, frameCount_d;

    always_comb begin
        hCount_d = hCount_q;
        vCount_d = vCount_q;
        lineWrap = 1'b0;
        if (pix_ce) begin
            if (hCount_q == H_LAST) begin
                hCount_d = '0;
                lineWrap = 1'b1;
                if (vCount_q == V_LAST) begin
                    vCount_d = '0;
                end else begin
                    vCount_d = vCount_q + 10'd1;
                end
            end else begin
                hCount_d = hCount_q + 10'd1;
            end
        end
    end

    // Phases step on the last count of the current phase, so the decode below
    // lines up with the counter value being loaded on the same edge.
    always_comb begin
        hPhase_d = hPhase_q;
        if (pix_ce) begin
            unique case (hPhase_q)
                PH_ACTIVE: if (hCount_q == H_ACT_END)  hPhase_d = PH_FRONT;
                PH_FRONT:  if (hCount_q == H_FP_END)   hPhase_d = PH_SYNC;
                PH_SYNC:   if (hCount_q == H_SYNC_END) hPhase_d = PH_BACK;
                PH_BACK:   if (hCount_q == H_LAST)     hPhase_d = PH_ACTIVE;
                default:                               hPhase_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        vPhase_d = vPhase_q;
        if (lineWrap) begin
            unique case (vPhase_q)
                PH_ACTIVE: if (vCount_q == V_ACT_END)  vPhase_d = PH_FRONT;
                PH_FRONT:  if (vCount_q == V_FP_END)   vPhase_d = PH_SYNC;
                PH_SYNC:   if (vCount_q == V_SYNC_END) vPhase_d = PH_BACK;
                PH_BACK:   if (vCount_q == V_LAST)     vPhase_d = PH_ACTIVE;
                default:                               vPhase_d = PH_ACTIVE;
            endcase
        end
    end

    always_comb begin
        blank_d      = (hPhase_d == PH_ACTIVE) && (vPhase_d == PH_ACTIVE);
        hs_d         = (hPhase_d != PH_SYNC);
        vs_d         = (vPhase_d != PH_SYNC);
        lineStart_d  = lineWrap;
        frameStart_d = lineWrap && (vCount_q == V_LAST);
        frameCount_d = frameStart_d ? frameCount_q + 16'd1 : frameCount_q;
    end

    // Reset parks on the last pixel of a frame so the first enabled edge enters (0,0)
    // and rolls the frame counter over to 0.
    always_ff @(posedge vga_clk or posedge reset) begin
        if (reset) begin
            hCount_q     <= H_LAST;
            vCount_q     <= V_LAST;
            hPhase_q     <= PH_BACK;
            vPhase_q     <= PH_BACK;
            blank_q      <= 1'b0;
            hs_q         <= 1'b1;
            vs_q         <= 1'b1;
            frameStart_q <= 1'b0;
            lineStart_q  <= 1'b0;
            frameCount_q <= 16'hFFFF;
        end else begin
            hCount_q     <= hCount_d;
            vCount_q     <= vCount_d;
            hPhase_q     <= hPhase_d;
            vPhase_q     <= vPhase_d;
            blank_q      <= blank_d;
            hs_q         <= hs_d;
            vs_q         <= vs_d;
            frameStart_q <= frameStart_d;
            lineStart_q  <= lineStart_d;
            frameCount_q <= frameCount_d;
        end
    end

    assign DrawX       = hCount_q;
    assign DrawY       = vCount_q;
    assign blank       = blank_q;
    assign hs          = hs_q;
    assign vs          = vs_q;
    assign frame_start = frameStart_q;
    assign line_start  = lineStart_q;
    assign frame_count = frameCount_q;

endmodule

// File: tb/tb_vga_scan_generator.sv
// Directed bench: full-size instance for reset, line timing and pixel-enable behaviour,
// plus a tiny-geometry instance so whole frames fit in a short run.
module tb_vga_scan_generator;

    logic        vga_clk;
    logic        reset;
    logic        pix_ce;

    logic [9:0]  dX, dY;
    logic        dBlank, dHs, dVs, dFs, dLs;
    logic [15:0] dFc;

    logic [9:0]  sX, sY;
    logic        sBlank, sHs, sVs, sFs, sLs;
    logic [15:0] sFc;

    int tests = 0;
    int fails = 0;

    vga_scan_generator dut (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .DrawX       (dX),
        .DrawY       (dY),
        .blank       (dBlank),
        .hs          (dHs),
        .vs          (dVs),
        .frame_start (dFs),
        .line_start  (dLs),
        .frame_count (dFc)
    );

    // Small geometry: H_TOTAL 15 (sync at x 10..12), V_TOTAL 13 (sync at y 8..9), 195 cycles/frame.
    vga_scan_generator #(
        .H_ACTIVE(8), .H_FP(2), .H_SYNC(3), .H_BP(2),
        .V_ACTIVE(6), .V_FP(2), .V_SYNC(2), .V_BP(3)
    ) dutS (
        .vga_clk     (vga_clk),
        .reset       (reset),
        .pix_ce      (pix_ce),
        .DrawX       (sX),
        .DrawY       (sY),
        .blank       (sBlank),
        .hs          (sHs),
        .vs          (sVs),
        .frame_start (sFs),
        .line_start  (sLs),
        .frame_count (sFc)
    );

    initial vga_clk = 1'b0;
    always #5 vga_clk = ~vga_clk;

    task automatic doReset(input logic ce);
        @(negedge vga_clk);
        reset  = 1'b1;
        pix_ce = ce;
        @(negedge vga_clk);
        reset  = 1'b0;
    endtask

    task automatic test_reset;
        @(negedge vga_clk);
        #2 reset = 1'b1;
        #1;
        tests++; if (dX !== 10'd799) begin fails++; $display("[TB] FAIL reset_drawx: got %0d, want 799", dX); end
        tests++; if (dY !== 10'd524) begin fails++; $display("[TB] FAIL reset_drawy: got %0d, want 524", dY); end
        tests++; if ({dBlank, dHs, dVs, dFs, dLs} !== 5'b01100) begin fails++; $display("[TB] FAIL reset_flags: got %b, want 01100", {dBlank, dHs, dVs, dFs, dLs}); end
        tests++; if (dFc !== 16'hFFFF) begin fails++; $display("[TB] FAIL reset_fcount: got %h, want FFFF", dFc); end
        tests++; if (sX !== 10'd14 || sY !== 10'd12) begin fails++; $display("[TB] FAIL reset_small_xy: got %0d,%0d, want 14,12", sX, sY); end
        pix_ce = 1'b1;
        @(negedge vga_clk);
        reset = 1'b0;
        @(negedge vga_clk);
        tests++; if (dX !== 10'd0 || dY !== 10'd0) begin fails++; $display("[TB] FAIL first_edge_xy: got %0d,%0d, want 0,0", dX, dY); end
        tests++; if ({dBlank, dHs, dVs} !== 3'b111) begin fails++; $display("[TB] FAIL first_edge_flags: got %b, want 111", {dBlank, dHs, dVs}); end
        tests++; if ({dFs, dLs} !== 2'b11) begin fails++; $display("[TB] FAIL first_edge_strobes: got %b, want 11", {dFs, dLs}); end
        tests++; if (dFc !== 16'h0000) begin fails++; $display("[TB] FAIL first_edge_fcount_wrap: got %h, want 0000", dFc); end
    endtask

    task automatic test_hsweep;
        int xyBad = 0, blankBad = 0, hsBad = 0, vsBad = 0, lsBad = 0, fsBad = 0;
        int firstLs = -1, secondLs = -1;
        doReset(1'b1);
        for (int i = 0; i < 1700; i++) begin
            int x;
            int y;
            logic expBlank;
            logic expHs;
            x = i % 800;
            y = i / 800;
            expBlank = (x < 640);
            expHs = !(x >= 656 && x <= 751);
            @(negedge vga_clk);
            if (dX !== 10'(x) || dY !== 10'(y)) xyBad++;
            if (dBlank !== expBlank) blankBad++;
            if (dHs !== expHs) hsBad++;
            if (dVs !== 1'b1) vsBad++;
            if (dLs !== (x == 0)) lsBad++;
            if (dFs !== (i == 0)) fsBad++;
            if (dLs === 1'b1) begin
                if (firstLs < 0) firstLs = i;
                else if (secondLs < 0) secondLs = i;
            end
            if (i == 639) begin tests++; if (dBlank !== 1'b1) begin fails++; $display("[TB] FAIL blank_x639: got %b, want 1", dBlank); end end
            if (i == 640) begin tests++; if (dBlank !== 1'b0) begin fails++; $display("[TB] FAIL blank_x640: got %b, want 0", dBlank); end end
            if (i == 655) begin tests++; if (dHs !== 1'b1) begin fails++; $display("[TB] FAIL hs_x655: got %b, want 1", dHs); end end
            if (i == 656) begin tests++; if (dHs !== 1'b0) begin fails++; $display("[TB] FAIL hs_x656: got %b, want 0", dHs); end end
            if (i == 751) begin tests++; if (dHs !== 1'b0) begin fails++; $display("[TB] FAIL hs_x751: got %b, want 0", dHs); end end
            if (i == 752) begin tests++; if (dHs !== 1'b1) begin fails++; $display("[TB] FAIL hs_x752: got %b, want 1", dHs); end end
        end
        tests++; if (xyBad !== 0) begin fails++; $display("[TB] FAIL hsweep_xy: %0d bad cycles, want 0", xyBad); end
        tests++; if (blankBad !== 0) begin fails++; $display("[TB] FAIL hsweep_blank: %0d bad cycles, want 0", blankBad); end
        tests++; if (hsBad !== 0) begin fails++; $display("[TB] FAIL hsweep_hs: %0d bad cycles, want 0", hsBad); end
        tests++; if (vsBad !== 0) begin fails++; $display("[TB] FAIL hsweep_vs: %0d bad cycles, want 0", vsBad); end
        tests++; if (lsBad !== 0) begin fails++; $display("[TB] FAIL hsweep_line_start: %0d bad cycles, want 0", lsBad); end
        tests++; if (fsBad !== 0) begin fails++; $display("[TB] FAIL hsweep_frame_start: %0d bad cycles, want 0", fsBad); end
        tests++; if (secondLs - firstLs !== 800) begin fails++; $display("[TB] FAIL line_period: got %0d, want 800", secondLs - firstLs); end
    endtask

    task automatic test_pixce_half_rate;
        int count = 0, xyBad = 0, flagBad = 0, lsBad = 0, dblBad = 0, fcBad = 0, lsPulses = 0;
        logic prevLs;
        doReset(1'b1);
        @(negedge vga_clk);
        prevLs = dLs;
        for (int i = 0; i < 1700; i++) begin
            logic ce;
            int x;
            int y;
            ce = (i % 2 == 1);
            pix_ce = ce;
            @(negedge vga_clk);
            if (ce) count++;
            x = count % 800;
            y = count / 800;
            if (dX !== 10'(x) || dY !== 10'(y)) xyBad++;
            if (dBlank !== (x < 640) || dHs !== !(x >= 656 && x <= 751)) flagBad++;
            if (dLs !== (ce && x == 0)) lsBad++;
            if ((dLs && prevLs) || dFs) dblBad++;
            if (dFc !== 16'h0000) fcBad++;
            if (dLs === 1'b1) lsPulses++;
            prevLs = dLs;
        end
        pix_ce = 1'b1;
        tests++; if (xyBad !== 0) begin fails++; $display("[TB] FAIL halfrate_xy: %0d bad cycles, want 0", xyBad); end
        tests++; if (flagBad !== 0) begin fails++; $display("[TB] FAIL halfrate_hold_flags: %0d bad cycles, want 0", flagBad); end
        tests++; if (lsBad !== 0) begin fails++; $display("[TB] FAIL halfrate_line_start: %0d bad cycles, want 0", lsBad); end
        tests++; if (dblBad !== 0) begin fails++; $display("[TB] FAIL halfrate_strobe_width: %0d bad cycles, want 0", dblBad); end
        tests++; if (fcBad !== 0) begin fails++; $display("[TB] FAIL halfrate_fcount_hold: %0d bad cycles, want 0", fcBad); end
        tests++; if (lsPulses !== 1) begin fails++; $display("[TB] FAIL halfrate_ls_pulses: got %0d, want 1", lsPulses); end
        tests++; if (dX !== 10'd50 || dY !== 10'd1) begin fails++; $display("[TB] FAIL halfrate_final_xy: got %0d,%0d, want 50,1", dX, dY); end
    endtask

    task automatic test_frame_small;
        int xyBad = 0, blankBad = 0, hsBad = 0, vsBad = 0, strobeBad = 0, fcBad = 0, vsLow = 0;
        int firstFs = -1, secondFs = -1;
        doReset(1'b1);
        for (int i = 0; i < 410; i++) begin
            int x;
            int y;
            int f;
            x = i % 15;
            y = (i / 15) % 13;
            f = i / 195;
            @(negedge vga_clk);
            if (sX !== 10'(x) || sY !== 10'(y)) xyBad++;
            if (sBlank !== (x < 8 && y < 6)) blankBad++;
            if (sHs !== !(x >= 10 && x <= 12)) hsBad++;
            if (sVs !== !(y >= 8 && y <= 9)) vsBad++;
            if (sLs !== (x == 0) || sFs !== (i % 195 == 0)) strobeBad++;
            if (sFc !== 16'(f)) fcBad++;
            if (sVs === 1'b0) vsLow++;
            if (sFs === 1'b1) begin
                if (firstFs < 0) firstFs = i;
                else if (secondFs < 0) secondFs = i;
            end
            if (i == 195) begin tests++; if (sFc !== 16'd1 || sFs !== 1'b1) begin fails++; $display("[TB] FAIL frame2_start: got fc=%0d fs=%b, want fc=1 fs=1", sFc, sFs); end end
        end
        tests++; if (xyBad !== 0) begin fails++; $display("[TB] FAIL frame_xy: %0d bad cycles, want 0", xyBad); end
        tests++; if (blankBad !== 0) begin fails++; $display("[TB] FAIL frame_blank: %0d bad cycles, want 0", blankBad); end
        tests++; if (hsBad !== 0) begin fails++; $display("[TB] FAIL frame_hs: %0d bad cycles, want 0", hsBad); end
        tests++; if (vsBad !== 0) begin fails++; $display("[TB] FAIL frame_vs: %0d bad cycles, want 0", vsBad); end
        tests++; if (vsLow !== 60) begin fails++; $display("[TB] FAIL frame_vs_low_count: got %0d, want 60", vsLow); end
        tests++; if (strobeBad !== 0) begin fails++; $display("[TB] FAIL frame_strobes: %0d bad cycles, want 0", strobeBad); end
        tests++; if (fcBad !== 0) begin fails++; $display("[TB] FAIL frame_fcount: %0d bad cycles, want 0", fcBad); end
        tests++; if (secondFs - firstFs !== 195) begin fails++; $display("[TB] FAIL frame_period: got %0d, want 195", secondFs - firstFs); end
    endtask

    task automatic test_midline_reset;
        doReset(1'b1);
        repeat (1901) @(negedge vga_clk);
        tests++; if (dX !== 10'd300 || dY !== 10'd2) begin fails++; $display("[TB] FAIL midreset_position: got %0d,%0d, want 300,2", dX, dY); end
        #2 reset = 1'b1;
        #1;
        tests++; if (dX !== 10'd799 || dY !== 10'd524) begin fails++; $display("[TB] FAIL midreset_xy: got %0d,%0d, want 799,524", dX, dY); end
        tests++; if ({dBlank, dHs, dVs, dFs, dLs} !== 5'b01100 || dFc !== 16'hFFFF) begin fails++; $display("[TB] FAIL midreset_state: got flags=%b fc=%h, want 01100 FFFF", {dBlank, dHs, dVs, dFs, dLs}, dFc); end
        @(negedge vga_clk);
        reset  = 1'b0;
        pix_ce = 1'b0;
        @(negedge vga_clk);
        tests++; if (dX !== 10'd799 || dY !== 10'd524 || dBlank !== 1'b0 || dFs !== 1'b0 || dFc !== 16'hFFFF) begin fails++; $display("[TB] FAIL midreset_hold: got x=%0d y=%0d blank=%b fs=%b fc=%h", dX, dY, dBlank, dFs, dFc); end
        pix_ce = 1'b1;
        @(negedge vga_clk);
        tests++; if (dX !== 10'd0 || dY !== 10'd0 || {dFs, dLs} !== 2'b11 || dFc !== 16'h0000) begin fails++; $display("[TB] FAIL midreset_first_edge: got x=%0d y=%0d strobes=%b fc=%h, want 0 0 11 0000", dX, dY, {dFs, dLs}, dFc); end
    endtask

    initial begin
        reset  = 1'b0;
        pix_ce = 1'b0;
        test_reset();
        test_hsweep();
        test_pixce_half_rate();
        test_frame_small();
        test_midline_reset();
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
